// File: rtl/cv32e40p_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_pkg
// Shared constants for the fault-tolerant RV32C compressor:
//   - RV32 base opcodes / funct fields recognised by the encoder
//   - RV32C quadrant, funct3 and funct4 values used to build the 16-bit words
//   - the 17-bit voted word type {compressible, instr[15:0]}
//   - the bitwise 2-of-3 majority helper used by the voter
// -----------------------------------------------------------------------------
package cv32e40p_pkg;

    // RV32 base opcodes
    localparam logic [6:0] OPCODE_OPIMM  = 7'h13;
    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] OPCODE_SYSTEM = 7'h73;

    // funct fields shared by ADD and ADDI
    localparam logic [2:0] FUNCT3_ADD_ADDI = 3'b000;
    localparam logic [6:0] FUNCT7_ADD      = 7'b0000000;

    // Exact-match instructions
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] INSTR_EBREAK = {12'h001, 5'd0, 3'b000, 5'd0, OPCODE_SYSTEM};

    // RV32C quadrants
    localparam logic [1:0] C_OP_Q1 = 2'b01;
    localparam logic [1:0] C_OP_Q2 = 2'b10;

    // RV32C funct3 / funct4 selectors
    localparam logic [2:0] C_FUNCT3_ADDI = 3'b000;
    localparam logic [2:0] C_FUNCT3_LI   = 3'b010;
    localparam logic [3:0] C_FUNCT4_MV   = 4'b1000;
    localparam logic [3:0] C_FUNCT4_ADD  = 4'b1001;

    // Fixed compressed encodings
    localparam logic [15:0] C_INSTR_NOP    = 16'h0001;
    localparam logic [15:0] C_INSTR_EBREAK = 16'h9002;

    // Width of the voted word {compressible, instr[15:0]}
    localparam int unsigned CWORD_W = 17;

    typedef logic [CWORD_W-1:0] cword_t;

    // Bitwise 2-of-3 majority of three replica words
    function automatic cword_t maj3(input cword_t a, input cword_t b, input cword_t c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/cv32e40p_compressor.sv
// -----------------------------------------------------------------------------
// cv32e40p_compressor
// Single-replica, purely combinational RV32 -> RV32C encoder for a fixed subset
// (NOP, EBREAK, ADDI-as-C.LI/C.MV/C.ADDI, ADD-as-C.MV/C.ADD). Rules are tried
// in priority order; anything else yields compressible_o=0 and instr_o=0.
// Ports:
//   instr_i        [31:0] uncompressed instruction
//   instr_o        [15:0] compressed encoding (0 when not compressible)
//   compressible_o        1 when instr_o is a valid RV32C encoding
// -----------------------------------------------------------------------------
module cv32e40p_compressor
    import cv32e40p_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [15:0] instr_o,
    output logic        compressible_o
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic        is_addi_s;
    logic        is_add_s;
    logic        imm_small_s;
    logic        imm_zero_s;
    logic        rd_nz_s;
    logic        rs1_nz_s;
    logic        rs2_nz_s;
    logic        rd_eq_rs1_s;
    logic [15:0] instr_c_s;
    logic        comp_s;

    assign opcode_s    = instr_i[6:0];
    assign rd_s        = instr_i[11:7];
    assign funct3_s    = instr_i[14:12];
    assign rs1_s       = instr_i[19:15];
    assign rs2_s       = instr_i[24:20];
    assign funct7_s    = instr_i[31:25];

    assign is_addi_s   = (opcode_s == OPCODE_OPIMM) && (funct3_s == FUNCT3_ADD_ADDI);
    assign is_add_s    = (opcode_s == OPCODE_OP) && (funct3_s == FUNCT3_ADD_ADDI) &&
                         (funct7_s == FUNCT7_ADD);

    // imm[11:0] = instr[31:20]; it fits in 6 signed bits when imm[11:5] are all copies of imm[5]
    assign imm_small_s = (instr_i[31:25] == {7{instr_i[25]}});
    assign imm_zero_s  = (instr_i[31:20] == 12'h000);

    assign rd_nz_s     = (rd_s != 5'd0);
    assign rs1_nz_s    = (rs1_s != 5'd0);
    assign rs2_nz_s    = (rs2_s != 5'd0);
    assign rd_eq_rs1_s = (rd_s == rs1_s);

    // Priority-ordered encoding rules
    always_comb begin
        instr_c_s = 16'h0000;
        comp_s    = 1'b0;
        if (instr_i == INSTR_NOP) begin
            instr_c_s = C_INSTR_NOP;
            comp_s    = 1'b1;
        end else if (instr_i == INSTR_EBREAK) begin
            instr_c_s = C_INSTR_EBREAK;
            comp_s    = 1'b1;
        end else if (is_addi_s && !rs1_nz_s && rd_nz_s && imm_small_s) begin
            instr_c_s = {C_FUNCT3_LI, instr_i[25], rd_s, instr_i[24:20], C_OP_Q1};
            comp_s    = 1'b1;
        end else if (is_addi_s && imm_zero_s && rd_nz_s && rs1_nz_s) begin
            instr_c_s = {C_FUNCT4_MV, rd_s, rs1_s, C_OP_Q2};
            comp_s    = 1'b1;
        end else if (is_addi_s && rd_eq_rs1_s && rd_nz_s && !imm_zero_s && imm_small_s) begin
            instr_c_s = {C_FUNCT3_ADDI, instr_i[25], rd_s, instr_i[24:20], C_OP_Q1};
            comp_s    = 1'b1;
        end else if (is_add_s && !rs1_nz_s && rd_nz_s && rs2_nz_s) begin
            instr_c_s = {C_FUNCT4_MV, rd_s, rs2_s, C_OP_Q2};
            comp_s    = 1'b1;
        end else if (is_add_s && rd_eq_rs1_s && rd_nz_s && rs2_nz_s) begin
            instr_c_s = {C_FUNCT4_ADD, rd_s, rs2_s, C_OP_Q2};
            comp_s    = 1'b1;
        end else begin
            instr_c_s = 16'h0000;
            comp_s    = 1'b0;
        end
    end

    assign instr_o        = instr_c_s;
    assign compressible_o = comp_s;

endmodule

// File: rtl/cv32e40p_compressed_encoder_ft.sv
// -----------------------------------------------------------------------------
// cv32e40p_compressed_encoder_ft
// Triplicated RV32 -> RV32C compressor. Three replica encoders feed a voter on
// the 17-bit word {compressible, instr}; the winner is registered behind a
// single valid/ready output stage (one-cycle latency, full throughput).
// Replicas that disagree with the vote are tracked and flagged broken.
//
// Build option: CV32E40P_COMPRESSOR_LEAKY_CNT_EN
//   defined   : 4-bit leaky per-replica counter (+1 on mismatch, -1 on accepted
//               agreement, floor 0, saturating); broken at ERR_THRESHOLD.
//   undefined : first mismatch marks the replica broken; ERR_THRESHOLD unused.
//
// Parameters:
//   ERR_THRESHOLD  mismatch count that declares a replica broken (1..15)
// Ports:
//   clk                 clock, rising edge
//   rst                 synchronous active-high reset
//   instr_i  [2:0][31:0] replica instructions
//   valid_i / ready_o    input handshake (ready_o = !valid_o || ready_i)
//   instr_o  [15:0]      voted compressed instruction (0 if not compressible)
//   compressible_o       voted compressible flag
//   valid_o / ready_i    output handshake
//   set_broken_i [2:0]   force replica broken (also excluded from the vote now)
//   is_broken_o  [2:0]   sticky per-replica broken flags
//   fatal_o              all three replicas broken
// -----------------------------------------------------------------------------
module cv32e40p_compressed_encoder_ft
    import cv32e40p_pkg::*;
#(
    parameter int unsigned ERR_THRESHOLD = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0][31:0] instr_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [15:0]      instr_o,
    output logic             compressible_o,
    output logic             valid_o,
    input  logic             ready_i,
    input  logic [2:0]       set_broken_i,
    output logic [2:0]       is_broken_o,
    output logic             fatal_o
);

    if ((ERR_THRESHOLD < 32'd1) || (ERR_THRESHOLD > 32'd15)) begin : g_bad_threshold
        $error("cv32e40p_compressed_encoder_ft: ERR_THRESHOLD must lie in 1..15");
    end

    cword_t [2:0] rep_word_s;
    cword_t       voted_s;
    logic   [2:0] eff_broken_s;
    logic   [2:0] mismatch_s;
    logic   [2:0] hit_s;
    logic   [2:0] broken_nxt_s;
    logic         accept_s;

    logic         valid_r;
    logic [15:0]  instr_r;
    logic         comp_r;
    logic [2:0]   is_broken_r;
    logic         fatal_r;

    for (genvar g = 0; g < 3; g++) begin : g_rep
        cv32e40p_compressor u_comp (
            .instr_i        (instr_i[g]),
            .instr_o        (rep_word_s[g][15:0]),
            .compressible_o (rep_word_s[g][16])
        );
    end

    assign ready_o  = !valid_r || ready_i;
    assign accept_s = valid_i && ready_o;

    // A forced-broken replica leaves the vote in the same cycle it is forced
    assign eff_broken_s = is_broken_r | set_broken_i;

    // Voter: majority when all healthy, else lowest-index healthy, else replica 0
    always_comb begin
        voted_s = rep_word_s[0];
        case (eff_broken_s)
            3'b000: begin
                voted_s = maj3(rep_word_s[0], rep_word_s[1], rep_word_s[2]);
            end
            3'b111: begin
                voted_s = rep_word_s[0];
            end
            default: begin
                if (!eff_broken_s[0]) begin
                    voted_s = rep_word_s[0];
                end else if (!eff_broken_s[1]) begin
                    voted_s = rep_word_s[1];
                end else begin
                    voted_s = rep_word_s[2];
                end
            end
        endcase
    end

    // Per-replica disagreement on an accepted input; already-broken replicas are ignored
    always_comb begin
        mismatch_s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (accept_s && !is_broken_r[k]) begin
                mismatch_s[k] = (rep_word_s[k] != voted_s);
            end else begin
                mismatch_s[k] = 1'b0;
            end
        end
    end

`ifdef CV32E40P_COMPRESSOR_LEAKY_CNT_EN
    localparam logic [3:0] THRESHOLD_C = 4'(ERR_THRESHOLD);

    logic [2:0][3:0] err_cnt_r;
    logic [2:0][3:0] err_cnt_nxt_s;

    // Leaky counter next state: up on mismatch (saturating), down on agreement (floor 0)
    always_comb begin
        err_cnt_nxt_s = err_cnt_r;
        for (int k = 0; k < 3; k++) begin
            if (accept_s && !is_broken_r[k]) begin
                if (mismatch_s[k]) begin
                    if (err_cnt_r[k] < THRESHOLD_C) begin
                        err_cnt_nxt_s[k] = err_cnt_r[k] + 4'd1;
                    end else begin
                        err_cnt_nxt_s[k] = THRESHOLD_C;
                    end
                end else if (err_cnt_r[k] != 4'd0) begin
                    err_cnt_nxt_s[k] = err_cnt_r[k] - 4'd1;
                end else begin
                    err_cnt_nxt_s[k] = 4'd0;
                end
            end else begin
                err_cnt_nxt_s[k] = err_cnt_r[k];
            end
        end
    end

    // Counter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= '{default: 4'd0};
        end else begin
            err_cnt_r <= err_cnt_nxt_s;
        end
    end

    // Broken is declared on the edge where the counter reaches the threshold
    always_comb begin
        hit_s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            hit_s[k] = (err_cnt_nxt_s[k] >= THRESHOLD_C);
        end
    end
`else
    assign hit_s = mismatch_s;
`endif

    assign broken_nxt_s = is_broken_r | set_broken_i | hit_s;

    // Sticky broken flags and the all-broken fatal indication
    always_ff @(posedge clk) begin
        if (rst) begin
            is_broken_r <= 3'b000;
            fatal_r     <= 1'b0;
        end else begin
            is_broken_r <= broken_nxt_s;
            fatal_r     <= &broken_nxt_s;
        end
    end

    // Output stage: load on acceptance, hold while stalled downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            instr_r <= 16'h0000;
            comp_r  <= 1'b0;
        end else if (ready_o) begin
            valid_r <= valid_i;
            if (valid_i) begin
                instr_r <= voted_s[15:0];
                comp_r  <= voted_s[16];
            end
        end
    end

    assign valid_o        = valid_r;
    assign instr_o        = instr_r;
    assign compressible_o = comp_r;
    assign is_broken_o    = is_broken_r;
    assign fatal_o        = fatal_r;

endmodule

// File: tb/tb_cv32e40p_compressed_encoder_ft.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cv32e40p_compressed_encoder_ft. A reference encoder,
// voter and broken-flag model produce expected words that are queued on
// acceptance and compared by a negedge monitor when the DUT hands them over.
// Scenario tasks add directed checks against literal values.
// -----------------------------------------------------------------------------
module tb_cv32e40p_compressed_encoder_ft;

    localparam int THR = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0][31:0] instr_i = '0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [15:0]      instr_o;
    logic             compressible_o;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic [2:0]       set_broken_i = 3'b000;
    logic [2:0]       is_broken_o;
    logic             fatal_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [16:0] q[$];
    logic        mv = 1'b0;
    logic [2:0]  m_brk = 3'b000;
    logic        m_fatal = 1'b0;
    int          m_cnt[3] = '{0, 0, 0};
    logic [16:0] mon_exp;

    cv32e40p_compressed_encoder_ft #(.ERR_THRESHOLD(THR)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_i        (instr_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .instr_o        (instr_o),
        .compressible_o (compressible_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .set_broken_i   (set_broken_i),
        .is_broken_o    (is_broken_o),
        .fatal_o        (fatal_o)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_enc(input logic [31:0] x);
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic signed [11:0] imm;
        logic               addi;
        logic               add;
        logic               fits;
        rd   = x[11:7];
        rs1  = x[19:15];
        rs2  = x[24:20];
        imm  = x[31:20];
        addi = (x[6:0] == 7'h13) && (x[14:12] == 3'b000);
        add  = (x[6:0] == 7'h33) && (x[14:12] == 3'b000) && (x[31:25] == 7'd0);
        fits = (imm >= -12'sd32) && (imm <= 12'sd31);
        if (x == 32'h0000_0013) return {1'b1, 16'h0001};
        if (x == 32'h0010_0073) return {1'b1, 16'h9002};
        if (addi && rs1 == 5'd0 && rd != 5'd0 && fits)
            return {1'b1, 3'b010, imm[5], rd, imm[4:0], 2'b01};
        if (addi && imm == 12'sd0 && rd != 5'd0 && rs1 != 5'd0)
            return {1'b1, 4'b1000, rd, rs1, 2'b10};
        if (addi && rd == rs1 && rd != 5'd0 && imm != 12'sd0 && fits)
            return {1'b1, 3'b000, imm[5], rd, imm[4:0], 2'b01};
        if (add && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0)
            return {1'b1, 4'b1000, rd, rs2, 2'b10};
        if (add && rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
            return {1'b1, 4'b1001, rd, rs2, 2'b10};
        return 17'h0_0000;
    endfunction

    function automatic logic [16:0] vote_m(input logic [2:0][16:0] w, input logic [2:0] brk);
        if (brk == 3'b000) return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
        if (!brk[0]) return w[0];
        if (!brk[1]) return w[1];
        if (!brk[2]) return w[2];
        return w[0];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [11:0] imm;
        rd  = 5'($urandom_range(0, 31));
        rs  = ($urandom_range(0, 2) == 0) ? 5'd0 : (($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31)));
        imm = ($urandom_range(0, 1) == 0) ? 12'($signed(6'($urandom_range(0, 63)))) : 12'($urandom);
        case ($urandom_range(0, 4))
            0: return {imm, rs, 3'b000, rd, 7'h13};
            1: return {7'd0, 5'($urandom_range(0, 31)), rs, 3'b000, rd, 7'h33};
            2: return 32'($urandom);
            3: return 32'h0000_0013;
            default: return 32'h0010_0073;
        endcase
    endfunction

    // Model one clock: queue expected word on acceptance and update flag model
    task automatic tick();
        logic [2:0][16:0] w;
        logic [16:0]      v;
        logic             acc;
        logic [2:0]       nb;
        logic             mv_n;
        acc = valid_i && (!mv || ready_i);
        for (int k = 0; k < 3; k++) w[k] = ref_enc(instr_i[k]);
        v  = vote_m(w, m_brk | set_broken_i);
        nb = m_brk | set_broken_i;
        if (acc) begin
            q.push_back(v);
            for (int k = 0; k < 3; k++) begin
                if (!m_brk[k]) begin
`ifdef CV32E40P_COMPRESSOR_LEAKY_CNT_EN
                    if (w[k] != v) m_cnt[k] = (m_cnt[k] >= THR) ? THR : m_cnt[k] + 1;
                    else if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
                    if (m_cnt[k] >= THR) nb[k] = 1'b1;
`else
                    if (w[k] != v) nb[k] = 1'b1;
`endif
                end
            end
        end
        mv_n = acc ? 1'b1 : (ready_i ? 1'b0 : mv);
        @(posedge clk);
        #1;
        mv      = mv_n;
        m_brk   = nb;
        m_fatal = &nb;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        valid_i      = 1'b0;
        ready_i      = 1'b0;
        set_broken_i = 3'b000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst     = 1'b0;
        q.delete();
        mv      = 1'b0;
        m_brk   = 3'b000;
        m_fatal = 1'b0;
        m_cnt   = '{0, 0, 0};
    endtask

    // Scoreboard monitor: state flags every cycle, data at each output handshake
    always @(negedge clk) begin
        if (!rst) begin
            n_vec++;
            if (valid_o !== mv || is_broken_o !== m_brk || fatal_o !== m_fatal) begin
                n_err++;
                $display("FAIL monitor_state: got valid_o=%b is_broken_o=%b fatal_o=%b, expected %b %b %b",
                         valid_o, is_broken_o, fatal_o, mv, m_brk, m_fatal);
            end
            if (valid_o && ready_i) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard_empty: got output %h, expected no output", {compressible_o, instr_o});
                end else begin
                    mon_exp = q.pop_front();
                    if ({compressible_o, instr_o} !== mon_exp) begin
                        n_err++;
                        $display("FAIL scoreboard_data: got %h, expected %h", {compressible_o, instr_o}, mon_exp);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (valid_o !== 1'b0 || instr_o !== 16'h0000 || compressible_o !== 1'b0 ||
            is_broken_o !== 3'b000 || fatal_o !== 1'b0 || ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got v=%b i=%h c=%b b=%b f=%b r=%b, expected 0 0000 0 000 0 1",
                     valid_o, instr_o, compressible_o, is_broken_o, fatal_o, ready_o);
        end
    endtask

    task automatic test_passthrough();
        logic [31:0] ins[4] = '{32'h0010_8093, 32'h0000_0013, 32'h00B0_0533, 32'h0010_0073};
        logic [15:0] exp[4] = '{16'h0085, 16'h0001, 16'h852E, 16'h9002};
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr_i = {3{ins[i]}};
            valid_i = 1'b1;
            tick();
            n_vec++;
            if (valid_o !== 1'b1 || compressible_o !== 1'b1 || instr_o !== exp[i]) begin
                n_err++;
                $display("FAIL passthrough[%0d]: got v=%b c=%b i=%h, expected 1 1 %h",
                         i, valid_o, compressible_o, instr_o, exp[i]);
            end
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_noncompressible();
        logic [31:0] ins[2] = '{32'h0000_0000, 32'h0200_8093};
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instr_i = {3{ins[i]}};
            valid_i = 1'b1;
            tick();
            n_vec++;
            if (valid_o !== 1'b1 || compressible_o !== 1'b0 || instr_o !== 16'h0000) begin
                n_err++;
                $display("FAIL noncompressible[%0d]: got v=%b c=%b i=%h, expected 1 0 0000",
                         i, valid_o, compressible_o, instr_o);
            end
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        ready_i = 1'b1;
        instr_i = {3{32'h0010_8093}};
        valid_i = 1'b1;
        tick();
        instr_i = {3{32'h00B0_0533}};
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure_ready[%0d]: got %b, expected 0", i, ready_o);
            end
            tick();
            n_vec++;
            if (valid_o !== 1'b1 || instr_o !== 16'h0085 || compressible_o !== 1'b1) begin
                n_err++;
                $display("FAIL backpressure_hold[%0d]: got v=%b i=%h, expected 1 0085", i, valid_o, instr_o);
            end
        end
        ready_i = 1'b1;
        #1;
        n_vec++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_release: got ready_o=%b, expected 1", ready_o);
        end
        tick();
        n_vec++;
        if (valid_o !== 1'b1 || instr_o !== 16'h852E) begin
            n_err++;
            $display("FAIL backpressure_next: got v=%b i=%h, expected 1 852e", valid_o, instr_o);
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_single_fault();
        logic [2:0] exp_b;
        do_reset();
        ready_i    = 1'b1;
        instr_i[0] = 32'h0010_8093;
        instr_i[1] = 32'h0010_8093;
        instr_i[2] = 32'h0000_0013;
        valid_i    = 1'b1;
        for (int a = 1; a <= 4; a++) begin
            tick();
`ifdef CV32E40P_COMPRESSOR_LEAKY_CNT_EN
            exp_b = (a == 4) ? 3'b100 : 3'b000;
`else
            exp_b = 3'b100;
`endif
            n_vec++;
            if (instr_o !== 16'h0085 || compressible_o !== 1'b1 || is_broken_o !== exp_b) begin
                n_err++;
                $display("FAIL single_fault[%0d]: got i=%h c=%b b=%b, expected 0085 1 %b",
                         a, instr_o, compressible_o, is_broken_o, exp_b);
            end
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_leaky_decay();
        logic exp_b1;
        do_reset();
        ready_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instr_i[0] = 32'h0010_8093;
            instr_i[2] = 32'h0010_8093;
            instr_i[1] = (i % 2 == 0) ? 32'h0000_0013 : 32'h0010_8093;
            tick();
`ifdef CV32E40P_COMPRESSOR_LEAKY_CNT_EN
            exp_b1 = 1'b0;
`else
            exp_b1 = 1'b1;
`endif
            n_vec++;
            if (is_broken_o[1] !== exp_b1 || instr_o !== 16'h0085) begin
                n_err++;
                $display("FAIL leaky_decay[%0d]: got b1=%b i=%h, expected %b 0085", i, is_broken_o[1], instr_o, exp_b1);
            end
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_set_broken();
        do_reset();
        ready_i      = 1'b1;
        instr_i[0]   = 32'h0010_8093;
        instr_i[1]   = 32'h0010_8093;
        instr_i[2]   = 32'h0000_0013;
        valid_i      = 1'b1;
        set_broken_i = 3'b011;
        tick();
        n_vec++;
        if (instr_o !== 16'h0001 || compressible_o !== 1'b1 || is_broken_o !== 3'b011 || fatal_o !== 1'b0) begin
            n_err++;
            $display("FAIL set_broken_011: got i=%h c=%b b=%b f=%b, expected 0001 1 011 0",
                     instr_o, compressible_o, is_broken_o, fatal_o);
        end
        set_broken_i = 3'b111;
        tick();
        n_vec++;
        if (instr_o !== 16'h0085 || fatal_o !== 1'b1 || is_broken_o !== 3'b111) begin
            n_err++;
            $display("FAIL set_broken_111: got i=%h f=%b b=%b, expected 0085 1 111", instr_o, fatal_o, is_broken_o);
        end
        set_broken_i = 3'b000;
        valid_i      = 1'b0;
        tick();
        n_vec++;
        if (fatal_o !== 1'b1 || is_broken_o !== 3'b111) begin
            n_err++;
            $display("FAIL broken_sticky: got f=%b b=%b, expected 1 111", fatal_o, is_broken_o);
        end
        do_reset();
        n_vec++;
        if (fatal_o !== 1'b0 || is_broken_o !== 3'b000) begin
            n_err++;
            $display("FAIL broken_reset_clear: got f=%b b=%b, expected 0 000", fatal_o, is_broken_o);
        end
    endtask

    task automatic test_reset_midtransfer();
        ready_i = 1'b0;
        instr_i = {3{32'h0010_8093}};
        valid_i = 1'b1;
        tick();
        n_vec++;
        if (valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_pending: got valid_o=%b, expected 1", valid_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_drop: got valid_o=%b, expected 0", valid_o);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            instr_i = {3{rand_instr()}};
            valid_i = 1'($urandom_range(0, 1));
            ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL random_drain: got %0d pending entries, expected 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_noncompressible();
        test_backpressure();
        test_single_fault();
        test_leaky_decay();
        test_set_broken();
        test_reset_midtransfer();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
